// File: rtl/trap_sequencer.sv
// trap_sequencer: sequences M-mode trap entry and mret through one CSR port, then redirects fetch.
module trap_sequencer #(
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] ECALL_CAUSE = 64'd11,
    parameter logic [XLEN-1:0] TIMER_CAUSE = 64'h8000_0000_0000_0007
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_instr_valid,
    input  logic [XLEN-1:0] i_instr_pc,
    input  logic            i_is_ecall,
    input  logic            i_is_mret,
    input  logic            i_irq_timer,
    input  logic            i_pipe_csr_wen,
    input  logic [11:0]     i_pipe_csr_addr,
    input  logic [XLEN-1:0] i_pipe_csr_wdata,
    output logic [11:0]     o_csr_raddr,
    input  logic [XLEN-1:0] i_csr_rdata,
    output logic            o_csr_wen,
    output logic [11:0]     o_csr_waddr,
    output logic [XLEN-1:0] o_csr_wdata,
    output logic            o_busy,
    output logic            o_redirect,
    output logic [XLEN-1:0] o_redirect_pc
);
    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] SAVE_EPC    = 3'd1;
    localparam logic [2:0] SAVE_CAUSE  = 3'd2;
    localparam logic [2:0] SAVE_STATUS = 3'd3;
    localparam logic [2:0] MRET_STATUS = 3'd4;
    localparam logic [2:0] REDIRECT    = 3'd5;

    logic [2:0]      r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_cause;
    logic [XLEN-1:0] r_redirect_pc;
    logic            r_mret;
    logic            w_idle;
    logic            w_take_irq;
    logic            w_trap;
    logic            w_mret;
    logic [XLEN-1:0] w_trap_status;
    logic [XLEN-1:0] w_mret_status;
    logic [XLEN-1:0] w_target;

    // rdata is mstatus while idle, so MIE gates the interrupt combinationally
    assign w_idle     = r_state == IDLE;
    assign w_take_irq = i_instr_valid & i_irq_timer & i_csr_rdata[3];
    assign w_trap     = w_idle & (w_take_irq | (i_instr_valid & i_is_ecall));
    assign w_mret     = w_idle & i_instr_valid & i_is_mret & ~w_trap;
    assign w_target   = r_mret ? i_csr_rdata : i_csr_rdata & {{(XLEN-2){1'b1}}, 2'b00};

    always_comb begin
        w_trap_status        = i_csr_rdata;
        w_trap_status[7]     = i_csr_rdata[3];
        w_trap_status[3]     = 1'b0;
        w_trap_status[12:11] = 2'b11;
        w_mret_status        = i_csr_rdata;
        w_mret_status[3]     = i_csr_rdata[7];
        w_mret_status[7]     = 1'b1;
        w_mret_status[12:11] = 2'b11;
    end

    assign o_csr_raddr   = (r_state == REDIRECT) ? (r_mret ? 12'h341 : 12'h305) : 12'h300;
    assign o_busy        = ~i_reset & (~w_idle | w_trap | w_mret);
    assign o_redirect    = ~i_reset & (r_state == REDIRECT);
    assign o_redirect_pc = (r_state == REDIRECT) ? w_target : r_redirect_pc;

    always_comb begin
        o_csr_wen   = 1'b0;
        o_csr_waddr = i_pipe_csr_addr;
        o_csr_wdata = i_pipe_csr_wdata;
        case (r_state)
            IDLE:        o_csr_wen = i_pipe_csr_wen;
            SAVE_EPC:    begin o_csr_wen = 1'b1; o_csr_waddr = 12'h341; o_csr_wdata = r_pc; end
            SAVE_CAUSE:  begin o_csr_wen = 1'b1; o_csr_waddr = 12'h342; o_csr_wdata = r_cause; end
            SAVE_STATUS: begin o_csr_wen = 1'b1; o_csr_waddr = 12'h300; o_csr_wdata = w_trap_status; end
            MRET_STATUS: begin o_csr_wen = 1'b1; o_csr_waddr = 12'h300; o_csr_wdata = w_mret_status; end
            default:     o_csr_wen = 1'b0;
        endcase
        if (i_reset) o_csr_wen = 1'b0;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_pc          <= '0;
            r_cause       <= '0;
            r_mret        <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_trap) begin
                        r_state <= SAVE_EPC;
                        r_pc    <= i_instr_pc;
                        r_cause <= w_take_irq ? TIMER_CAUSE : ECALL_CAUSE;
                        r_mret  <= 1'b0;
                    end else if (w_mret) begin
                        r_state <= MRET_STATUS;
                        r_mret  <= 1'b1;
                    end
                end
                SAVE_EPC:    r_state <= SAVE_CAUSE;
                SAVE_CAUSE:  r_state <= SAVE_STATUS;
                SAVE_STATUS: r_state <= REDIRECT;
                MRET_STATUS: r_state <= REDIRECT;
                REDIRECT: begin
                    r_state       <= IDLE;
                    r_redirect_pc <= w_target;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: directed trap/mret scenarios against a per-transaction CSR-write script model.
module tb_trap_sequencer;
    localparam logic [63:0] TIMER = 64'h8000_0000_0000_0007;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0, ecall = 1'b0, mret = 1'b0, irq = 1'b0;
    logic [63:0] ipc = '0;
    logic        pwen = 1'b0;
    logic [11:0] paddr = '0;
    logic [63:0] pdata = '0;
    logic [11:0] csr_raddr, csr_waddr;
    logic [63:0] csr_rdata, csr_wdata, redirect_pc;
    logic        csr_wen, busy, redirect;
    int          checks = 0;
    int          errors = 0;

    // CSR file seen by the DUT (hw) and the model's own view (mdl): mstatus, mtvec, mepc, mcause
    logic [63:0] hw  [4];
    logic [63:0] mdl [4];

    typedef struct packed {
        logic [2:0]  kind;
        logic [11:0] a;
        logic [63:0] d;
    } step_t;
    step_t q[$];

    step_t       m_s;
    logic        m_busy, m_wen, m_rd, m_tirq, m_trap, m_mret;
    logic [11:0] m_a;
    logic [63:0] m_d, m_st, m_rpc = '0;

    trap_sequencer dut (
        .i_clock(clk), .i_reset(rst), .i_instr_valid(valid), .i_instr_pc(ipc),
        .i_is_ecall(ecall), .i_is_mret(mret), .i_irq_timer(irq),
        .i_pipe_csr_wen(pwen), .i_pipe_csr_addr(paddr), .i_pipe_csr_wdata(pdata),
        .o_csr_raddr(csr_raddr), .i_csr_rdata(csr_rdata), .o_csr_wen(csr_wen),
        .o_csr_waddr(csr_waddr), .o_csr_wdata(csr_wdata), .o_busy(busy),
        .o_redirect(redirect), .o_redirect_pc(redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic int idx(input logic [11:0] a);
        return a == 12'h300 ? 0 : a == 12'h305 ? 1 : a == 12'h341 ? 2 : a == 12'h342 ? 3 : -1;
    endfunction

    assign csr_rdata = idx(csr_raddr) >= 0 ? hw[idx(csr_raddr)] : 64'h0;

    always @(posedge clk) if (csr_wen && idx(csr_waddr) >= 0) hw[idx(csr_waddr)] <= csr_wdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Model: an accepted trap/mret expands into its scripted sequence of per-cycle outcomes
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            m_rpc = '0;
            chk("rst_busy", {63'd0, busy}, 64'd0);
            chk("rst_csr_wen", {63'd0, csr_wen}, 64'd0);
            chk("rst_redirect", {63'd0, redirect}, 64'd0);
        end else begin
            m_rd = 1'b0; m_wen = 1'b0; m_a = '0; m_d = '0;
            if (q.size() != 0) begin
                m_s = q.pop_front();
                m_busy = 1'b1;
                m_st = mdl[0];
                case (m_s.kind)
                    3'd0: begin m_wen = 1'b1; m_a = m_s.a; m_d = m_s.d; end
                    3'd1: begin
                        m_st[7] = m_st[3]; m_st[3] = 1'b0; m_st[12:11] = 2'b11;
                        m_wen = 1'b1; m_a = 12'h300; m_d = m_st;
                    end
                    3'd2: begin
                        m_st[3] = m_st[7]; m_st[7] = 1'b1; m_st[12:11] = 2'b11;
                        m_wen = 1'b1; m_a = 12'h300; m_d = m_st;
                    end
                    3'd3: begin m_rd = 1'b1; m_rpc = mdl[1] & ~64'h3; end
                    default: begin m_rd = 1'b1; m_rpc = mdl[2]; end
                endcase
            end else begin
                m_tirq = valid & irq & mdl[0][3];
                m_trap = m_tirq | (valid & ecall);
                m_mret = valid & mret & ~m_trap;
                m_busy = m_trap | m_mret;
                m_wen = pwen; m_a = paddr; m_d = pdata;
                if (m_trap) begin
                    q.push_back('{3'd0, 12'h341, ipc});
                    q.push_back('{3'd0, 12'h342, m_tirq ? TIMER : 64'd11});
                    q.push_back('{3'd1, 12'h0, 64'h0});
                    q.push_back('{3'd3, 12'h0, 64'h0});
                end else if (m_mret) begin
                    q.push_back('{3'd2, 12'h0, 64'h0});
                    q.push_back('{3'd4, 12'h0, 64'h0});
                end
            end
            chk("busy", {63'd0, busy}, {63'd0, m_busy});
            chk("csr_wen", {63'd0, csr_wen}, {63'd0, m_wen});
            if (m_wen) begin
                chk("csr_waddr", {52'd0, csr_waddr}, {52'd0, m_a});
                chk("csr_wdata", csr_wdata, m_d);
            end
            chk("redirect", {63'd0, redirect}, {63'd0, m_rd});
            chk("redirect_pc", redirect_pc, m_rpc);
            if (m_wen && idx(m_a) >= 0) mdl[idx(m_a)] = m_d;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pwrite(input logic [11:0] a, input logic [63:0] d);
        pwen = 1'b1; paddr = a; pdata = d;
        cyc();
        pwen = 1'b0;
    endtask

    task automatic drive(input logic [63:0] pc, input logic e, input logic m, input logic ir);
        valid = 1'b1; ipc = pc; ecall = e; mret = m; irq = ir;
        #1;
    endtask

    task automatic release_instr();
        cyc();
        valid = 1'b0; ecall = 1'b0; mret = 1'b0; irq = 1'b0;
    endtask

    initial begin
        cyc();
        chk("reset_busy", {63'd0, busy}, 64'd0);
        cyc();
        rst = 1'b0;
        #1;
        chk("reset_redirect_pc", redirect_pc, 64'd0);
        pwrite(12'h300, 64'h8);
        pwrite(12'h305, 64'h8000_0101);
        pwrite(12'h341, 64'h0);
        pwrite(12'h342, 64'h0);

        drive(64'h8000_0010, 1'b1, 1'b0, 1'b0);
        chk("t1_accept_busy", {63'd0, busy}, 64'd1);
        release_instr();
        repeat (3) cyc();
        chk("t1_redirect", {63'd0, redirect}, 64'd1);
        chk("t1_redirect_pc", redirect_pc, 64'h8000_0100);
        cyc();
        chk("t1_idle_busy", {63'd0, busy}, 64'd0);
        chk("t1_mepc", hw[2], 64'h8000_0010);
        chk("t1_mcause", hw[3], 64'd11);
        chk("t1_mstatus", hw[0], 64'h1880);

        pwrite(12'h341, 64'h8000_0014);
        drive(64'h8000_0040, 1'b0, 1'b1, 1'b0);
        chk("t2_accept_busy", {63'd0, busy}, 64'd1);
        release_instr();
        cyc();
        chk("t2_redirect", {63'd0, redirect}, 64'd1);
        chk("t2_redirect_pc", redirect_pc, 64'h8000_0014);
        cyc();
        chk("t2_busy_low", {63'd0, busy}, 64'd0);
        chk("t2_mstatus", hw[0], 64'h1888);

        drive(64'h100, 1'b1, 1'b0, 1'b1);
        chk("t3_accept_busy", {63'd0, busy}, 64'd1);
        release_instr();
        repeat (4) cyc();
        chk("t3_mcause", hw[3], TIMER);
        chk("t3_mepc", hw[2], 64'h100);
        chk("t3_mstatus", hw[0], 64'h1880);

        drive(64'h200, 1'b0, 1'b0, 1'b1);
        chk("t4_masked_busy", {63'd0, busy}, 64'd0);
        cyc();
        valid = 1'b0;
        pwrite(12'h300, 64'h1888);
        drive(64'h204, 1'b0, 1'b0, 1'b1);
        chk("t4_taken_busy", {63'd0, busy}, 64'd1);
        release_instr();
        repeat (4) cyc();
        chk("t4_mepc", hw[2], 64'h204);
        chk("t4_mcause", hw[3], TIMER);

        drive(64'h300, 1'b1, 1'b0, 1'b0);
        release_instr();
        cyc();
        pwen = 1'b1; paddr = 12'h305; pdata = 64'hdead;
        #1;
        chk("t5_busy_waddr", {52'd0, csr_waddr}, 64'h342);
        chk("t5_busy_wdata", csr_wdata, 64'd11);
        cyc();
        pwen = 1'b0;
        repeat (2) cyc();
        chk("t5_mtvec_kept", hw[1], 64'h8000_0101);
        pwen = 1'b1; paddr = 12'h305; pdata = 64'h8000_0201;
        #1;
        chk("t5_pass_wen", {63'd0, csr_wen}, 64'd1);
        chk("t5_pass_waddr", {52'd0, csr_waddr}, 64'h305);
        chk("t5_pass_wdata", csr_wdata, 64'h8000_0201);
        cyc();
        pwen = 1'b0;
        chk("t5_mtvec_new", hw[1], 64'h8000_0201);

        drive(64'h400, 1'b1, 1'b0, 1'b0);
        release_instr();
        cyc();
        rst = 1'b1;
        #1;
        chk("t6_rst_wen", {63'd0, csr_wen}, 64'd0);
        cyc();
        rst = 1'b0;
        #1;
        chk("t6_idle_busy", {63'd0, busy}, 64'd0);
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("t6_no_redirect", {63'd0, redirect}, 64'd0);
        end

        drive(64'h500, 1'b0, 1'b1, 1'b1);
        chk("t7_accept_busy", {63'd0, busy}, 64'd1);
        release_instr();
        cyc();
        chk("t7_redirect", {63'd0, redirect}, 64'd1);
        chk("t7_redirect_pc", redirect_pc, 64'h400);
        cyc();
        chk("t7_mstatus", hw[0], 64'h1880);
        repeat (2) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
